// File: rtl/i2c_arbiter_if.sv
// Requester channel into the I2C arbiter: one level request plus its command fields.
// Latency: gnt one cycle after req is seen in idle; done/rdata/err arrive together.
// Backpressure: req is held until done; the arbiter never drops a granted request.
//
// Signals:
//   req    - level request, held until done
//   addr   - 7-bit I2C device address
//   mask   - byte lanes, bit 3 = MSB byte (sent first)
//   wdata  - write data
//   write  - 1 = write, 0 = read
//   gnt    - one-cycle pulse when this requester wins arbitration
//   done   - one-cycle completion pulse
//   rdata  - masked read data, valid in the done cycle and held afterwards
//   err    - error flag, valid in the done cycle and held afterwards
// Modports: master = requester side, slave = arbiter side.

interface i2c_arbiter_if;
   logic        req;
   logic [6:0]  addr;
   logic [3:0]  mask;
   logic [31:0] wdata;
   logic        write;
   logic        gnt;
   logic        done;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, addr, mask, wdata, write,
      input  gnt, done, rdata, err
   );

   modport slave (
      input  req, addr, mask, wdata, write,
      output gnt, done, rdata, err
   );
endinterface

// File: rtl/i2c_arbiter.sv
// Shares one i2c_master between two requesters (p0 = CPU bridge, p1 = radio init).
// Latency: req in idle -> gnt +1, master released +2; busy falling -> done +1.
// Backpressure: requests wait in IDLE while a transaction is in flight; round-robin on ties.
//
// Ports:
//   clk, reset        - single clock; reset is asynchronous, active-low
//   p0, p1            - requester channels (i2c_arbiter_if.slave)
//   m_reset           - active-high synchronous reset to the master; 1 whenever idle
//   m_device_addr,
//   m_mask, m_data_in,
//   m_write           - command fields, latched at grant and stable until completion
//   m_busy            - master busy
//   m_data_out        - master read data
//
// Optional feature: define I2C_ARBITER_TIMEOUT_EN to build a 16-bit watchdog that
// aborts a transaction with err=1 when the master fails to start within
// START_TIMEOUT clocks or fails to finish within XFER_TIMEOUT clocks.

module i2c_arbiter #(
   parameter int START_TIMEOUT = 1024,
   parameter int XFER_TIMEOUT  = 65535
) (
   input  logic         clk,
   input  logic         reset,
   i2c_arbiter_if.slave p0,
   i2c_arbiter_if.slave p1,
   output logic         m_reset,
   output logic [6:0]   m_device_addr,
   output logic [3:0]   m_mask,
   output logic [31:0]  m_data_in,
   output logic         m_write,
   input  logic         m_busy,
   input  logic [31:0]  m_data_out
);

   // Both limits must fit the 16-bit watchdog whether or not it is built, so a
   // configuration is portable between the two builds.
   if (START_TIMEOUT < 1 || START_TIMEOUT > 65535 ||
       XFER_TIMEOUT  < 1 || XFER_TIMEOUT  > 65535) begin : g_bad_timeout
      $error("i2c_arbiter: START_TIMEOUT and XFER_TIMEOUT must be in 1..65535");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_WAIT_START,
      S_WAIT_END,
      S_RESP
   } state_t;

   state_t state;
   logic   last;     // most recent winner; 1 after reset so port 0 wins first
   logic   win;      // port owning the transaction in flight
   logic   reject;   // zero-mask request: answered with err, master never released

`ifdef I2C_ARBITER_TIMEOUT_EN
   localparam logic [15:0] START_LIMIT = 16'(START_TIMEOUT);
   localparam logic [15:0] XFER_LIMIT  = 16'(XFER_TIMEOUT);
   logic [15:0] wdog;
`endif

   // Expand the byte-lane mask into a 32-bit bit mask.
   function automatic logic [31:0] lane_bits(input logic [3:0] m);
      return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
   endfunction

   // Round-robin pick: a lone requester always wins, on a tie the port that
   // did not win last time goes first.
   logic        pick1;
   logic [6:0]  pick_addr;
   logic [3:0]  pick_mask;
   logic [31:0] pick_wdata;
   logic        pick_write;

   assign pick1      = p1.req & (~p0.req | ~last);
   assign pick_addr  = pick1 ? p1.addr  : p0.addr;
   assign pick_mask  = pick1 ? p1.mask  : p0.mask;
   assign pick_wdata = pick1 ? p1.wdata : p0.wdata;
   assign pick_write = pick1 ? p1.write : p0.write;

   // Completion decision for the current cycle: fin moves the FSM to RESP and
   // loads the response registers of the winning port at the same edge.
   logic        fin;
   logic        fin_err;
   logic [31:0] fin_data;

   always_comb begin
      fin      = 1'b0;
      fin_err  = 1'b0;
      fin_data = '0;
      case (state)
         S_SETUP: begin
            if (reject) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end
         end
`ifdef I2C_ARBITER_TIMEOUT_EN
         S_WAIT_START: begin
            if (!m_busy && wdog == START_LIMIT) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end
         end
`endif
         S_WAIT_END: begin
            if (!m_busy) begin
               fin      = 1'b1;
               // Writes return zero; reads keep only the requested lanes.
               fin_data = m_write ? 32'd0 : (m_data_out & lane_bits(m_mask));
            end
`ifdef I2C_ARBITER_TIMEOUT_EN
            else if (wdog == XFER_LIMIT) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end
`endif
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         last          <= 1'b1;
         win           <= 1'b0;
         reject        <= 1'b0;
         m_reset       <= 1'b1;
         m_device_addr <= '0;
         m_mask        <= '0;
         m_data_in     <= '0;
         m_write       <= 1'b0;
         p0.gnt        <= 1'b0;
         p1.gnt        <= 1'b0;
         p0.done       <= 1'b0;
         p1.done       <= 1'b0;
         p0.rdata      <= '0;
         p1.rdata      <= '0;
         p0.err        <= 1'b0;
         p1.err        <= 1'b0;
`ifdef I2C_ARBITER_TIMEOUT_EN
         wdog          <= '0;
`endif
      end else begin
         p0.gnt  <= 1'b0;
         p1.gnt  <= 1'b0;
         p0.done <= 1'b0;
         p1.done <= 1'b0;

         case (state)
            S_IDLE: begin
               // The master runs whenever it is out of reset, so keep it held here.
               m_reset <= 1'b1;
               if (p0.req || p1.req) begin
                  state         <= S_SETUP;
                  last          <= pick1;
                  win           <= pick1;
                  reject        <= (pick_mask == 4'd0);
                  p0.gnt        <= ~pick1;
                  p1.gnt        <= pick1;
                  m_device_addr <= pick_addr;
                  m_mask        <= pick_mask;
                  m_data_in     <= pick_wdata;
                  m_write       <= pick_write;
               end
            end

            // Fields settle for one cycle with the master still held in reset;
            // a rejected request leaves through fin without releasing it.
            S_SETUP: begin
               if (!reject) begin
                  state   <= S_WAIT_START;
                  m_reset <= 1'b0;
`ifdef I2C_ARBITER_TIMEOUT_EN
                  wdog    <= '0;
`endif
               end
            end

            S_WAIT_START: begin
               if (m_busy) begin
                  state <= S_WAIT_END;
`ifdef I2C_ARBITER_TIMEOUT_EN
                  wdog  <= '0;
               end else begin
                  wdog  <= wdog + 16'd1;
`endif
               end
            end

            S_WAIT_END: begin
`ifdef I2C_ARBITER_TIMEOUT_EN
               wdog <= wdog + 16'd1;
`endif
            end

            S_RESP: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase

         // Overrides the per-state next state above when the transaction ends.
         if (fin) begin
            state   <= S_RESP;
            m_reset <= 1'b1;
            if (win) begin
               p1.done  <= 1'b1;
               p1.rdata <= fin_data;
               p1.err   <= fin_err;
            end else begin
               p0.done  <= 1'b1;
               p0.rdata <= fin_data;
               p0.err   <= fin_err;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of arbitration and response rules.
// Define I2C_ARBITER_TIMEOUT_EN to include the watchdog scenario.

module tb_i2c_arbiter;

   logic        clk;
   logic        reset;
   logic        m_reset;
   logic [6:0]  m_device_addr;
   logic [3:0]  m_mask;
   logic [31:0] m_data_in;
   logic        m_write;
   logic        m_busy;
   logic [31:0] m_data_out;

   i2c_arbiter_if p0 ();
   i2c_arbiter_if p1 ();

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   i2c_arbiter #(.START_TIMEOUT(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .p0            (p0),
      .p1            (p1),
      .m_reset       (m_reset),
      .m_device_addr (m_device_addr),
      .m_mask        (m_mask),
      .m_data_in     (m_data_in),
      .m_write       (m_write),
      .m_busy        (m_busy),
      .m_data_out    (m_data_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Master model: once out of reset it waits mm_delay cycles, is busy for
   // mm_len cycles, then stays idle until reset again (or never starts if hung).
   int          mm_phase = 0;
   int          mm_cnt   = 0;
   int          mm_delay = 2;
   int          mm_len   = 3;
   bit          mm_hang  = 1'b0;
   logic [31:0] mm_data  = '0;
   int          fall_cyc = -1;
   logic [31:0] fall_data = '0;

   initial begin
      m_busy     = 1'b0;
      m_data_out = '0;
      forever begin
         @(posedge clk);
         #1;
         if (m_reset !== 1'b0) begin
            mm_phase = 0;
            m_busy   = 1'b0;
         end else begin
            case (mm_phase)
               0: begin
                  mm_cnt   = 0;
                  mm_phase = mm_hang ? 4 : 1;
               end
               1: begin
                  mm_cnt++;
                  if (mm_cnt >= mm_delay) begin
                     m_busy     = 1'b1;
                     m_data_out = mm_data;
                     mm_cnt     = 0;
                     mm_phase   = 2;
                  end
               end
               2: begin
                  mm_cnt++;
                  if (mm_cnt >= mm_len) begin
                     m_busy    = 1'b0;
                     fall_cyc  = cyc;
                     fall_data = m_data_out;
                     mm_phase  = 3;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   initial begin
      #500us;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

   // Reference result: requested byte lanes of the master data, zero for writes.
   function automatic logic [31:0] exp_rdata(input logic [31:0] d, input logic [3:0] m,
                                             input logic w);
      logic [31:0] r;
      r = '0;
      if (!w)
         for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic set_req(input int port, input logic [6:0] a, input logic [3:0] m,
                          input logic [31:0] d, input logic w);
      if (port == 0) begin
         p0.req = 1'b1; p0.addr = a; p0.mask = m; p0.wdata = d; p0.write = w;
      end else begin
         p1.req = 1'b1; p1.addr = a; p1.mask = m; p1.wdata = d; p1.write = w;
      end
   endtask

   task automatic clr_req(input int port);
      if (port == 0) p0.req = 1'b0;
      else           p1.req = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clr_req(0);
      clr_req(1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Collected observations of one transaction (no judgement made here).
   typedef struct {
      int          g0, g1, mlow, dcyc, dport;
      logic [31:0] rd;
      logic        er, mr_done;
      bit          changed;
      logic [6:0]  a;
      logic [3:0]  m;
      logic [31:0] d;
      logic        w;
   } obs_t;

   // Watches until the first done (or budget expiry), recording grant/launch/done
   // cycles and the command fields; the completed requester drops req in its done cycle.
   task automatic observe(input int budget, input bit drop_mid, output obs_t o);
      int gc;
      gc = -1;
      o.g0 = -1; o.g1 = -1; o.mlow = -1; o.dcyc = -1; o.dport = -1;
      o.rd = '0; o.er = 1'b0; o.mr_done = 1'b0; o.changed = 1'b0;
      o.a = '0; o.m = '0; o.d = '0; o.w = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (p0.gnt === 1'b1 && o.g0 < 0) o.g0 = cyc;
         if (p1.gnt === 1'b1 && o.g1 < 0) o.g1 = cyc;
         if ((p0.gnt === 1'b1 || p1.gnt === 1'b1) && gc < 0) begin
            gc  = cyc;
            o.a = m_device_addr; o.m = m_mask; o.d = m_data_in; o.w = m_write;
         end else if (gc >= 0 && (m_device_addr !== o.a || m_mask !== o.m ||
                                   m_data_in !== o.d || m_write !== o.w)) begin
            o.changed = 1'b1;
         end
         if (m_reset === 1'b0 && o.mlow < 0) o.mlow = cyc;
         if (drop_mid && gc >= 0 && cyc == gc + 2) clr_req((o.g1 >= 0) ? 1 : 0);
         if (p0.done === 1'b1 || p1.done === 1'b1) begin
            o.dcyc    = cyc;
            o.dport   = (p1.done === 1'b1) ? 1 : 0;
            o.rd      = (o.dport == 1) ? p1.rdata : p0.rdata;
            o.er      = (o.dport == 1) ? p1.err : p0.err;
            o.mr_done = m_reset;
            clr_req(o.dport);
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      set_req(0, 7'h7F, 4'hF, 32'hFFFF_FFFF, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (m_reset !== 1'b1) begin
         bad++; $display("FAIL reset_m_reset: got %b expected 1", m_reset);
      end
      total++;
      if ({p0.gnt, p1.gnt, p0.done, p1.done, p0.err, p1.err} !== 6'b0) begin
         bad++; $display("FAIL reset_flags: got %b expected 000000",
                         {p0.gnt, p1.gnt, p0.done, p1.done, p0.err, p1.err});
      end
      total++;
      if ({p0.rdata, p1.rdata} !== 64'd0) begin
         bad++; $display("FAIL reset_rdata: got %h expected 0", {p0.rdata, p1.rdata});
      end
      total++;
      if ({m_device_addr, m_mask, m_data_in, m_write} !== 44'd0) begin
         bad++; $display("FAIL reset_m_fields: got %h expected 0",
                         {m_device_addr, m_mask, m_data_in, m_write});
      end
      clr_req(0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_single_read();
      obs_t o;
      int   t0;
      @(posedge clk); #1;
      mm_delay = 2; mm_len = 3; mm_data = 32'hA5B6_7788;
      t0 = cyc;
      set_req(0, 7'h3C, 4'b1100, 32'h0, 1'b0);
      observe(200, 1'b0, o);
      total++;
      if (o.g0 !== t0 + 1) begin
         bad++; $display("FAIL read_gnt_cycle: got %0d expected %0d", o.g0, t0 + 1);
      end
      total++;
      if (o.mlow !== t0 + 2) begin
         bad++; $display("FAIL read_launch_cycle: got %0d expected %0d", o.mlow, t0 + 2);
      end
      total++;
      if (o.dport !== 0 || o.dcyc !== fall_cyc + 1) begin
         bad++; $display("FAIL read_done: port %0d cycle %0d expected port 0 cycle %0d",
                         o.dport, o.dcyc, fall_cyc + 1);
      end
      total++;
      if (o.rd !== 32'hA5B6_0000 || o.er !== 1'b0) begin
         bad++; $display("FAIL read_data: got %h err %b expected a5b60000 err 0", o.rd, o.er);
      end
      total++;
      if (o.a !== 7'h3C || o.m !== 4'b1100 || o.w !== 1'b0 || o.mr_done !== 1'b1) begin
         bad++; $display("FAIL read_fields: addr %h mask %b write %b m_reset %b",
                         o.a, o.m, o.w, o.mr_done);
      end
   endtask

   task automatic test_simultaneous();
      obs_t o, o2;
      int   t0;
      do_reset();
      for (int round = 0; round < 2; round++) begin
         @(posedge clk); #1;
         mm_data = 32'hDEAD_BEEF;
         t0 = cyc;
         set_req(0, 7'h10, 4'b1111, 32'h0, 1'b0);
         set_req(1, 7'h20, 4'b0011, 32'h0, 1'b0);
         observe(200, 1'b0, o);
         total++;
         if (o.dport !== 0 || o.g0 !== t0 + 1 || o.g1 !== -1) begin
            bad++; $display("FAIL sim_first r%0d: port %0d g0 %0d g1 %0d expected port 0 g0 %0d",
                            round, o.dport, o.g0, o.g1, t0 + 1);
         end
         total++;
         if (o.rd !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL sim_rdata0 r%0d: got %h expected deadbeef", round, o.rd);
         end
         observe(200, 1'b0, o2);
         total++;
         if (o2.dport !== 1 || o2.g1 !== o.dcyc + 2) begin
            bad++; $display("FAIL sim_second r%0d: port %0d g1 %0d expected port 1 g1 %0d",
                            round, o2.dport, o2.g1, o.dcyc + 2);
         end
         total++;
         if (o2.rd !== 32'h0000_BEEF) begin
            bad++; $display("FAIL sim_rdata1 r%0d: got %h expected 0000beef", round, o2.rd);
         end
      end
   endtask

   task automatic test_field_stability();
      obs_t o;
      @(posedge clk); #1;
      mm_len = 6;
      set_req(1, 7'h55, 4'b0001, 32'h1122_3344, 1'b1);
      observe(200, 1'b1, o);
      mm_len = 3;
      total++;
      if (o.dport !== 1 || o.changed !== 1'b0) begin
         bad++; $display("FAIL stab_done: port %0d changed %b expected port 1 changed 0",
                         o.dport, o.changed);
      end
      total++;
      if (o.a !== 7'h55 || o.m !== 4'b0001 || o.d !== 32'h1122_3344 || o.w !== 1'b1) begin
         bad++; $display("FAIL stab_fields: addr %h mask %b data %h write %b",
                         o.a, o.m, o.d, o.w);
      end
      total++;
      if (o.rd !== 32'd0 || o.er !== 1'b0) begin
         bad++; $display("FAIL stab_rdata: got %h err %b expected 0 err 0", o.rd, o.er);
      end
   endtask

   task automatic test_zero_mask();
      obs_t o;
      int   t0;
      @(posedge clk); #1;
      t0 = cyc;
      set_req(1, 7'h22, 4'b0000, 32'h0000_FFFF, 1'b0);
      observe(50, 1'b0, o);
      total++;
      if (o.g1 !== t0 + 1 || o.dcyc !== t0 + 2 || o.dport !== 1) begin
         bad++; $display("FAIL zero_timing: g1 %0d done %0d port %0d expected %0d %0d 1",
                         o.g1, o.dcyc, o.dport, t0 + 1, t0 + 2);
      end
      total++;
      if (o.er !== 1'b1 || o.mlow !== -1) begin
         bad++; $display("FAIL zero_err: err %b launch %0d expected err 1 no launch",
                         o.er, o.mlow);
      end
   endtask

`ifdef I2C_ARBITER_TIMEOUT_EN
   task automatic test_timeout();
      obs_t o;
      int   t0;
      @(posedge clk); #1;
      mm_hang = 1'b1;
      t0 = cyc;
      set_req(0, 7'h01, 4'b1111, 32'h0, 1'b0);
      observe(200, 1'b0, o);
      mm_hang = 1'b0;
      total++;
      if (o.mlow !== t0 + 2 || o.dcyc !== t0 + 2 + 17 || o.dport !== 0) begin
         bad++; $display("FAIL timeout_cycle: launch %0d done %0d expected %0d %0d",
                         o.mlow, o.dcyc, t0 + 2, t0 + 19);
      end
      total++;
      if (o.er !== 1'b1 || o.rd !== 32'd0 || o.mr_done !== 1'b1) begin
         bad++; $display("FAIL timeout_resp: err %b rdata %h m_reset %b expected 1 0 1",
                         o.er, o.rd, o.mr_done);
      end
   endtask
`endif

   task automatic test_async_reset();
      obs_t o;
      int   t0;
      bit   got_busy;
      bit   seen_done;
      @(posedge clk); #1;
      mm_delay = 1; mm_len = 30;
      set_req(0, 7'h3C, 4'b1111, 32'h0, 1'b0);
      got_busy = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (m_busy === 1'b1) begin
            got_busy = 1'b1;
            break;
         end
      end
      repeat (3) @(negedge clk);
      total++;
      if (got_busy !== 1'b1 || m_reset !== 1'b0) begin
         bad++; $display("FAIL async_reach_busy: busy seen %b m_reset %b expected 1 0",
                         got_busy, m_reset);
      end
      #2;
      reset = 1'b0;
      #1;
      total++;
      if (m_reset !== 1'b1 || m_device_addr !== 7'd0) begin
         bad++; $display("FAIL async_immediate: m_reset %b addr %h expected 1 00",
                         m_reset, m_device_addr);
      end
      clr_req(0);
      seen_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (p0.done === 1'b1 || p1.done === 1'b1) seen_done = 1'b1;
      end
      total++;
      if (seen_done !== 1'b0) begin
         bad++; $display("FAIL async_no_done: got done %b expected 0", seen_done);
      end
      reset = 1'b1;
      mm_delay = 2; mm_len = 3;
      @(posedge clk); #1;
      mm_data = 32'h1234_5678;
      t0 = cyc;
      set_req(0, 7'h44, 4'b0110, 32'h0, 1'b0);
      observe(200, 1'b0, o);
      total++;
      if (o.g0 !== t0 + 1 || o.dport !== 0) begin
         bad++; $display("FAIL async_regrant: g0 %0d port %0d expected %0d 0",
                         o.g0, o.dport, t0 + 1);
      end
      total++;
      if (o.rd !== 32'h0034_5600 || o.er !== 1'b0) begin
         bad++; $display("FAIL async_rdata: got %h err %b expected 00345600 0", o.rd, o.er);
      end
   endtask

   task automatic test_random();
      logic [3:0]  hm [2];
      logic [31:0] hd [2];
      logic        hw [2];
      bit          busy_m, done_prev, done_now, pr0, pr1, exp_last, ew, exp_g, cur, cur_w;
      logic [3:0]  cur_mask;
      int          gcyc, exp_cyc;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic [3:0]  m;
      do_reset();
      busy_m = 0; done_prev = 0; pr0 = 0; pr1 = 0; exp_last = 1; cur = 0; cur_w = 0;
      cur_mask = '0; gcyc = 0;
      for (int p = 0; p < 2; p++) begin hm[p] = '0; hd[p] = '0; hw[p] = 1'b0; end
      for (int c = 0; c < 1200; c++) begin
         @(posedge clk); #1;
         if (c < 600) begin
            for (int p = 0; p < 2; p++) begin
               if (((p == 0) ? p0.req : p1.req) !== 1'b1 && $urandom_range(0, 2) == 0) begin
                  m = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
                  hm[p] = m; hd[p] = $urandom; hw[p] = 1'($urandom_range(0, 1));
                  set_req(p, 7'($urandom), hm[p], hd[p], hw[p]);
               end
            end
         end
         @(negedge clk);
         done_now = 0;
         exp_g = !busy_m && !done_prev && (pr0 || pr1);
         total++;
         if ((p0.gnt === 1'b1 || p1.gnt === 1'b1) !== exp_g) begin
            bad++; $display("FAIL rand_gnt c%0d: got %b%b expected any=%b",
                            cyc, p1.gnt, p0.gnt, exp_g);
         end else if (exp_g) begin
            ew = (pr0 && pr1) ? !exp_last : pr1;
            total++;
            if (p1.gnt !== ew || p0.gnt !== !ew) begin
               bad++; $display("FAIL rand_winner c%0d: got %b%b expected port %0d",
                               cyc, p1.gnt, p0.gnt, ew);
            end
            total++;
            if (m_mask !== hm[ew] || m_write !== hw[ew] || m_data_in !== hd[ew]) begin
               bad++; $display("FAIL rand_fields c%0d: mask %b wr %b data %h expected %b %b %h",
                               cyc, m_mask, m_write, m_data_in, hm[ew], hw[ew], hd[ew]);
            end
            exp_last = ew; cur = ew; busy_m = 1; gcyc = cyc;
            cur_mask = hm[ew]; cur_w = hw[ew];
            mm_data = $urandom; mm_delay = $urandom_range(1, 4); mm_len = $urandom_range(1, 5);
         end
         if (p0.done === 1'b1 || p1.done === 1'b1) begin
            total++;
            if (!busy_m || (cur ? p1.done : p0.done) !== 1'b1) begin
               bad++; $display("FAIL rand_done_port c%0d: got %b%b expected port %0d busy %b",
                               cyc, p1.done, p0.done, cur, busy_m);
            end else begin
               if (cur_mask == 4'd0) begin
                  exp_err = 1'b1; exp_cyc = gcyc + 1;
                  exp_rd = cur ? p1.rdata : p0.rdata;
               end else begin
                  exp_err = 1'b0; exp_cyc = fall_cyc + 1;
                  exp_rd = exp_rdata(fall_data, cur_mask, cur_w);
               end
               total++;
               if ((cur ? p1.err : p0.err) !== exp_err || (cur ? p1.rdata : p0.rdata) !== exp_rd
                   || cyc !== exp_cyc) begin
                  bad++; $display("FAIL rand_resp c%0d: err %b rdata %h expected err %b rdata %h at c%0d",
                                  cyc, cur ? p1.err : p0.err, cur ? p1.rdata : p0.rdata,
                                  exp_err, exp_rd, exp_cyc);
               end
            end
            busy_m = 0; done_now = 1;
            clr_req(cur ? 1 : 0);
         end
         pr0 = (p0.req === 1'b1);
         pr1 = (p1.req === 1'b1);
         done_prev = done_now;
         if (c >= 600 && !busy_m && !pr0 && !pr1) break;
      end
      total++;
      if (busy_m || pr0 || pr1) begin
         bad++; $display("FAIL rand_drain: busy %b req %b%b expected all idle", busy_m, pr1, pr0);
      end
   endtask

   initial begin
      reset = 1'b0;
      p0.req = 1'b0; p0.addr = '0; p0.mask = '0; p0.wdata = '0; p0.write = 1'b0;
      p1.req = 1'b0; p1.addr = '0; p1.mask = '0; p1.wdata = '0; p1.write = 1'b0;
      test_reset();
      test_single_read();
      test_simultaneous();
      test_field_stability();
      test_zero_mask();
`ifdef I2C_ARBITER_TIMEOUT_EN
      test_timeout();
`endif
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
